// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronise and filter the PS/2 lines, frame the 11-bit words,
// decode E0/F0 prefixes into key events (valid/ready FIFO) and track snake direction keys.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic [3:0] dir_held,
  output logic [3:0] dir_last,
  output logic       parity_err,
  output logic       frame_err,
  output logic       fifo_ovf
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_s_q, dat_s_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  logic          strobe, bit_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s_q     <= 2'b11;
      dat_s_q     <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s_q     <= {clk_s_q[0], ps2_clk};
      dat_s_q     <= {dat_s_q[0], ps2_dat};
      filt_prev_q <= filt_q;
      if (clk_s_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;
  assign bit_in = dat_s_q[1];

  // Frame FSM
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          acc_q, acc_d, perr_q, perr_d, ferr_q, ferr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    acc_d   = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = (state_q == IDLE || strobe) ? '0 : tmo_q + TW'(1);
    if (strobe) begin
      case (state_q)
        IDLE: if (!bit_in) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          shreg_d = {bit_in, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          if (!bit_in)                 ferr_d = 1'b1;
          else if (^{shreg_q, par_q})  acc_d  = 1'b1;
          else                         perr_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // Prefix decode; shreg_q is stable for the cycle after acceptance
  logic       ext_q, ext_d, brk_q, brk_d, push;
  logic [9:0] ev_in;

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (acc_q) begin
      case (shreg_q)
        8'hE0:        ext_d = 1'b1;
        8'hF0:        brk_d = 1'b1;
        8'h00, 8'hFF: begin ext_d = 1'b0; brk_d = 1'b0; end
        default:      begin push = 1'b1; ext_d = 1'b0; brk_d = 1'b0; end
      endcase
    end
  end

  assign ev_in = {brk_q, ext_q, shreg_q};

  // Direction tracking sees every event, including ones the FIFO drops
  logic [3:0] dsel, arrow_q, arrow_d, wasd_q, wasd_d, last_q, last_d;

  always_comb begin
    dsel = 4'b0000;
    if (ext_q) begin
      case (shreg_q)
        8'h75: dsel = 4'b0001;
        8'h72: dsel = 4'b0010;
        8'h6B: dsel = 4'b0100;
        8'h74: dsel = 4'b1000;
        default: dsel = 4'b0000;
      endcase
    end else begin
      case (shreg_q)
        8'h1D: dsel = 4'b0001;
        8'h1B: dsel = 4'b0010;
        8'h1C: dsel = 4'b0100;
        8'h23: dsel = 4'b1000;
        default: dsel = 4'b0000;
      endcase
    end
  end

  always_comb begin
    arrow_d = arrow_q;
    wasd_d  = wasd_q;
    last_d  = last_q;
    if (push && dsel != 4'b0000) begin
      if (brk_q) begin
        if (ext_q) arrow_d = arrow_q & ~dsel;
        else       wasd_d  = wasd_q & ~dsel;
      end else begin
        if (ext_q) arrow_d = arrow_q | dsel;
        else       wasd_d  = wasd_q | dsel;
        last_d = dsel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      arrow_q <= '0;
      wasd_q  <= '0;
      last_q  <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      arrow_q <= arrow_d;
      wasd_q  <= wasd_d;
      last_q  <= last_d;
    end
  end

  assign dir_held = arrow_q | wasd_q;
  assign dir_last = last_q;

  // Event FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
  logic [FIFO_DEPTH-1:0][9:0] mem_q;
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]                cnt_q;
  logic                       full, pop, wr, ovf_q;

  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (cnt_q != '0);
  assign pop      = ev_valid & ev_ready;
  assign wr       = push & (~full | pop);
  assign ev_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push & full & ~pop;
      if (wr) begin
        mem_q[wr_ptr_q] <= ev_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign fifo_ovf   = ovf_q;

endmodule
